// File: rtl/isa_seq_core.sv
// Clocked register-bank / ALU / RAM core: one instruction sequenced through IDLE, READ, EXEC, WB.
// Optional status flags (flag_z, flag_c, flag_v) are built when ISA_SEQ_CORE_FLAGS_EN is defined.
module isa_seq_core #(
    parameter  int DATA_W     = 32,
    parameter  int REG_ADDR_W = 5,
    parameter  int MEM_ADDR_W = 8,
    localparam int INSTR_W    = 32'd3 * REG_ADDR_W + 32'd5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [INSTR_W-1:0]    instr,
    input  logic                  ld_en,
    input  logic [REG_ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0]     ld_data,
    input  logic [MEM_ADDR_W-1:0] mem_raddr,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic [DATA_W-1:0]     result,
    output logic                  result_valid,
    output logic                  busy
`ifdef ISA_SEQ_CORE_FLAGS_EN
    ,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  flag_v
`endif
);

    localparam int REG_DEPTH = 32'd1 << REG_ADDR_W;
    localparam int MEM_DEPTH = 32'd1 << MEM_ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [INSTR_W-1:0]      instr_r;
    logic [DATA_W-1:0]       op1_r, op2_r, alu_s, result_r, mem_rdata_r;
    logic [DATA_W-1:0]       regs_r [REG_DEPTH];
    logic [DATA_W-1:0]       ram_r  [MEM_DEPTH];
    logic                    ready_r, busy_r, result_valid_r;
    logic [REG_ADDR_W-1:0]   rs1_s, rs2_s, rd_s;
    logic [2:0]              aluop_s;
    logic                    wb_reg_s, wr_mem_s;
    logic                    accept_s, host_ld_s, reg_wr_s, mem_wr_s;

    assign {rs1_s, rs2_s, rd_s, aluop_s, wb_reg_s, wr_mem_s} = instr_r;

    // Register 0 is never written, so it reads as zero from reset onwards.
    assign accept_s  = (state_r == ST_IDLE) && instr_valid;
    assign host_ld_s = (state_r == ST_IDLE) && !instr_valid && ld_en && (ld_addr != {REG_ADDR_W{1'b0}});
    assign reg_wr_s  = (state_r == ST_WB) && wb_reg_s && (rd_s != {REG_ADDR_W{1'b0}});
    assign mem_wr_s  = (state_r == ST_WB) && wr_mem_s;

    assign instr_ready  = ready_r;
    assign busy         = busy_r;
    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign mem_rdata    = mem_rdata_r;

    // Next-state sequencing
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (instr_valid) begin
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: state_nxt_s = ST_EXEC;
            ST_EXEC: state_nxt_s = ST_WB;
            ST_WB:   state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // ALU on the latched operands; shifts use only the low five bits of op2
    always_comb begin
        alu_s = {DATA_W{1'b0}};
        case (aluop_s)
            3'b000:  alu_s = op1_r + op2_r;
            3'b001:  alu_s = op1_r - op2_r;
            3'b010:  alu_s = op1_r & op2_r;
            3'b011:  alu_s = op1_r | op2_r;
            3'b100:  alu_s = op1_r ^ op2_r;
            3'b101:  alu_s = op1_r << op2_r[4:0];
            3'b110:  alu_s = op1_r >> op2_r[4:0];
            3'b111:  alu_s = {{(DATA_W-1){1'b0}}, ($signed(op1_r) < $signed(op2_r))};
            default: alu_s = {DATA_W{1'b0}};
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Instruction capture, operand fetch, result latch and handshake/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_r        <= {INSTR_W{1'b0}};
            op1_r          <= {DATA_W{1'b0}};
            op2_r          <= {DATA_W{1'b0}};
            result_r       <= {DATA_W{1'b0}};
            result_valid_r <= 1'b0;
            ready_r        <= 1'b1;
            busy_r         <= 1'b0;
        end else begin
            if (accept_s) begin
                instr_r <= instr;
            end
            if (state_r == ST_READ) begin
                op1_r <= regs_r[rs1_s];
                op2_r <= regs_r[rs2_s];
            end
            if (state_r == ST_EXEC) begin
                result_r <= alu_s;
            end
            result_valid_r <= (state_r == ST_EXEC);
            ready_r        <= (state_nxt_s == ST_IDLE);
            busy_r         <= (state_nxt_s != ST_IDLE);
        end
    end

    // Register bank: write-back has priority by state; host loads only land in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (reg_wr_s) begin
            regs_r[rd_s] <= result_r;
        end else if (host_ld_s) begin
            regs_r[ld_addr] <= ld_data;
        end
    end

    // Data RAM storage, intentionally without reset
    always_ff @(posedge clk) begin
        if (mem_wr_s) begin
            ram_r[op2_r[MEM_ADDR_W-1:0]] <= result_r;
        end
    end

    // Registered read-back port; a same-edge write returns the old word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rdata_r <= {DATA_W{1'b0}};
        end else begin
            mem_rdata_r <= ram_r[mem_raddr];
        end
    end

`ifdef ISA_SEQ_CORE_FLAGS_EN
    logic carry_s, ovf_s;
    logic flag_z_r, flag_c_r, flag_v_r;

    assign flag_z = flag_z_r;
    assign flag_c = flag_c_r;
    assign flag_v = flag_v_r;

    // Add carry shows as a wrapped sum; subtract carry means no borrow
    always_comb begin
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        case (aluop_s)
            3'b000: begin
                carry_s = (alu_s < op1_r);
                ovf_s   = (op1_r[DATA_W-1] == op2_r[DATA_W-1]) && (alu_s[DATA_W-1] != op1_r[DATA_W-1]);
            end
            3'b001: begin
                carry_s = (op1_r >= op2_r);
                ovf_s   = (op1_r[DATA_W-1] != op2_r[DATA_W-1]) && (alu_s[DATA_W-1] != op1_r[DATA_W-1]);
            end
            default: begin
                carry_s = 1'b0;
                ovf_s   = 1'b0;
            end
        endcase
    end

    // Flags follow the result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z_r <= 1'b0;
            flag_c_r <= 1'b0;
            flag_v_r <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            flag_z_r <= (alu_s == {DATA_W{1'b0}});
            flag_c_r <= carry_s;
            flag_v_r <= ovf_s;
        end
    end
`endif

endmodule
